move_collector: RTL
===================

// Module: move_collector
// PURPOSE
// - Downstream of the 8 column units. Drains each column's 48-bit move FIFO in column order 0..7.
// - Strips the per-column end marker and streams move words to the move-evaluation stage over a valid/ready handshake.
// - Counts moves and asserts done once all 8 columns are exhausted.
// PARAMETERS
// - NCOL     8   number of column units (fixed at 8 for a chess board)
// - WORDW    48  width of one column FIFO word (8 x 6-bit {x,y} fields)
// - CNTW     10  width of the total move counter (saturates)
// PORTS
// - clk        in   1        clock, rising edge
// - reset      in   1        asynchronous, active-high; clears all state
// - start      in   1        one-cycle pulse; begins a collection pass
// - col_done   in   8        done flag per column unit
// - col_empty  in   8        FIFO empty per column
// - col_data   in   8*WORDW  FIFO read data, column c at [c*48 +: 48]; valid 1 cycle after col_rden[c]
// - col_rden   out  8        one-hot FIFO read enable
// - out_valid  out  1        out_data/out_col valid
// - out_ready  in   1        downstream accepts when out_valid & out_ready
// - out_data   out  WORDW    move word
// - out_col    out  3        source column of out_data
// - move_count out  CNTW     words forwarded this pass, saturating at all-ones
// - busy       out  1        pass in progress
// - done       out  1        pass complete, held until next start or reset
// BEHAVIOUR
// - Reset: state IDLE, col_rden=0, out_valid=0, out_data=0, out_col=0, move_count=0, busy=0, done=0.
// - End marker: a word whose 8 6-bit fields are all identical (a self-to-self move). It is never forwarded.
// - States: IDLE -> (start) WAITC -> (col_done[ptr]) READ -> CHECK -> READ, or -> WAITC with ptr+1, or -> DONE.
// - IDLE: start clears move_count, sets ptr=0 and busy=1. start is ignored in every state other than IDLE and DONE.
// - WAITC: waits for col_done[ptr].
// - READ: drives col_rden[ptr]=1 for exactly 1 cycle, and only if !col_empty[ptr] and the output register is empty or being consumed this cycle. Otherwise it stalls.
// - CHECK: samples col_data[ptr] (1-cycle read latency).
//   - End marker: ptr==7 -> DONE, else ptr+1 -> WAITC.
//   - Otherwise: the word loads the output register, out_valid=1, out_col=ptr, move_count+1.
// - Sustained throughput is 1 word per 2 cycles.
// - Output register holds out_data/out_col stable while out_valid & !out_ready. out_valid drops the cycle after acceptance unless reloaded.
// - DONE: busy=0, done=1 only after the last forwarded word has been accepted (out_valid=0). start in DONE clears done and begins a new pass.
// - An empty FIFO after col_done without an end marker stalls in READ indefinitely. This is legal; there is no timeout.
// - move_count saturates at 2^CNTW-1 and never wraps.
// - Reset mid-pass aborts immediately. Any in-flight output word is dropped; out_valid=0 on the next edge.
// CONFIGURATION
// - MOVE_COLLECTOR_COLSTAT_EN defined:
//   - Adds output col_count [8*6-1:0], a 6-bit saturating count of forwarded words per column.
//   - Cleared on start and on reset.
// - MOVE_COLLECTOR_COLSTAT_EN undefined: the port and its counters are absent. All other behaviour is identical.
// STRUCTURE
// - Shared package chess_pkg holds:
//   - WORDW and the 6-bit square field width
//   - the collector state encoding (IDLE/WAITC/READ/CHECK/DONE)
//   - function is_end_marker(word)
// - One sub-module: move_out_reg, the 1-entry valid/ready output register with a load/accept interface.
// TESTING
// - Single column: col 3 holds 2 words then marker; others marker only; out_ready=1 -> 2 words with out_col=3, move_count=2, done.
// - Backpressure: out_ready=0 for 5 cycles with a word pending -> out_data stable, no col_rden pulses, no loss after release.
// - Ordering: col_done raised 7..0 in reverse -> outputs still appear in column order 0..7.
// - Marker only: all 8 FIFOs hold just a marker -> no out_valid, move_count=0, done within 8*3+2 cycles.
// - Reset mid-pass: assert reset while out_valid=1 in column 4 -> all outputs return to reset values; a new start restarts at column 0.
// - Saturation: CNTW=4, 20 words -> move_count holds 15.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared definitions for the move collection path: word geometry, collector states, end-marker test.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package chess_pkg;

    localparam int NCOL  = 8;
    localparam int WORDW = 48;
    localparam int SQW   = 6;
    localparam int PTRW  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAITC,
        ST_READ,
        ST_CHECK,
        ST_DONE
    } coll_state_t;

    // A self-to-self move (all eight square fields identical) terminates a column's list.
    function automatic logic is_end_marker(input logic [WORDW-1:0] word);
        logic same;
        same = 1'b1;
        for (int i = 1; i < WORDW / SQW; i++) begin
            if (word[i*SQW +: SQW] != word[SQW-1:0]) begin
                same = 1'b0;
            end
        end
        return same;
    endfunction

endpackage

// File: rtl/move_collector_out_reg.sv
// One-entry valid/ready output register holding a move word and its source column.
// Latency: 1 cycle from load to out_valid.
// Backpressure: holds data stable while out_valid & !out_ready; free tells the loader a slot is available.
module move_out_reg
    import chess_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORDW-1:0]  load_data,
    input  logic [PTRW-1:0]   load_col,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORDW-1:0]  out_data,
    output logic [PTRW-1:0]   out_col,
    output logic              free
);

    logic             valid_q, valid_d;
    logic [WORDW-1:0] data_q, data_d;
    logic [PTRW-1:0]  col_q, col_d;

    always_comb begin
        valid_d = load | (valid_q & ~out_ready);
        data_d  = load ? load_data : data_q;
        col_d   = load ? load_col : col_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            col_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            col_q   <= col_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_col   = col_q;
    assign free      = ~valid_q | out_ready;

endmodule

// File: rtl/move_collector.sv
// Drains the 8 column move FIFOs in order 0..7, strips end markers, streams words out; optional MOVE_COLLECTOR_COLSTAT_EN adds per-column counts.
// Latency: FIFO read to out_valid is 2 cycles; sustained 1 word per 2 cycles.
// Backpressure: no FIFO read is issued while the output register is full and not being accepted.
module move_collector
    import chess_pkg::*;
#(
    parameter int CNTW = 10
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NCOL-1:0]        col_done,
    input  logic [NCOL-1:0]        col_empty,
    input  logic [NCOL*WORDW-1:0]  col_data,
    output logic [NCOL-1:0]        col_rden,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORDW-1:0]       out_data,
    output logic [PTRW-1:0]        out_col,
    output logic [CNTW-1:0]        move_count,
    output logic                   busy,
    output logic                   done
`ifdef MOVE_COLLECTOR_COLSTAT_EN
    ,
    output logic [NCOL*SQW-1:0]    col_count
`endif
);

    coll_state_t      state_q, state_d;
    logic [PTRW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load;
    logic             start_pass;
    logic             out_free;
    logic [WORDW-1:0] cur_word;

    assign cur_word   = col_data[int'(ptr_q)*WORDW +: WORDW];
    assign start_pass = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        load     = 1'b0;
        col_rden = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAITC;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            ST_WAITC: begin
                if (col_done[ptr_q]) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (!col_empty[ptr_q] && out_free) begin
                    col_rden[ptr_q] = 1'b1;
                    state_d         = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (is_end_marker(cur_word)) begin
                    if (ptr_q == PTRW'(NCOL - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = ST_WAITC;
                    end
                end else begin
                    load    = 1'b1;
                    state_d = ST_READ;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // Completion is only reported once the final word has left the output register.
                if (!out_valid) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                if (start) begin
                    state_d = ST_WAITC;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    move_out_reg u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (cur_word),
        .load_col  (ptr_q),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_col   (out_col),
        .free      (out_free)
    );

    assign move_count = cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef MOVE_COLLECTOR_COLSTAT_EN
    logic [SQW-1:0] ccnt_q [NCOL];
    logic [SQW-1:0] ccnt_d [NCOL];

    always_comb begin
        for (int c = 0; c < NCOL; c++) begin
            ccnt_d[c] = ccnt_q[c];
            if (start_pass) begin
                ccnt_d[c] = '0;
            end else if (load && (ptr_q == PTRW'(c)) && (ccnt_q[c] != '1)) begin
                ccnt_d[c] = ccnt_q[c] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCOL; c++) begin
                ccnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCOL; c++) begin
                ccnt_q[c] <= ccnt_d[c];
            end
        end
    end

    always_comb begin
        col_count = '0;
        for (int c = 0; c < NCOL; c++) begin
            col_count[c*SQW +: SQW] = ccnt_q[c];
        end
    end
`endif

endmodule
